clock_set_ctrl: RTL and testbench

Time-setting and daylight-saving controller for the 12-hour clock counter. Decodes debounced mode/inc/dec buttons into an hour-then-minute edit sequence, holds the counter during editing, and commits the edited time with a one-cycle load. Also applies a one-shot ±1 hour DST adjustment on `dst_en` edges. Sits between the button debouncers and the clock counter's load/enable inputs.

---
 rtl/clock_set_ctrl_pkg.sv | 92 +++++++++
 rtl/clock_set_ctrl_if.sv | 37 +++
 rtl/clock_set_ctrl_btn_repeat.sv | 63 ++++++
 rtl/clock_set_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_set_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clock_pkg
//  Description : Shared types, field layout and wrap-around helpers for the
//                12-hour clock time-setting controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

    // Field widths of the packed 27-bit time word {hr, min, sec, ms}
    localparam int c_HR_W   = 5;
    localparam int c_MIN_W  = 6;
    localparam int c_SEC_W  = 6;
    localparam int c_MS_W   = 10;
    localparam int c_TIME_W = c_HR_W + c_MIN_W + c_SEC_W + c_MS_W;

    // Bit positions of each field inside the time word
    localparam int c_MS_LSB  = 0;
    localparam int c_SEC_LSB = c_MS_LSB  + c_MS_W;
    localparam int c_MIN_LSB = c_SEC_LSB + c_SEC_W;
    localparam int c_HR_LSB  = c_MIN_LSB + c_MIN_W;

    localparam logic [c_HR_W-1:0]  HR_MAX  = 5'd11;
    localparam logic [c_MIN_W-1:0] MIN_MAX = 6'd59;

    // Packed view of the time word; member order matches the bit layout
    typedef struct packed {
        logic [c_HR_W-1:0]  hr;
        logic [c_MIN_W-1:0] min;
        logic [c_SEC_W-1:0] sec;
        logic [c_MS_W-1:0]  ms;
    } clk_time_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    // Encoding of the field output
    localparam logic [1:0] c_FIELD_NONE = 2'b00;
    localparam logic [1:0] c_FIELD_HR   = 2'b01;
    localparam logic [1:0] c_FIELD_MIN  = 2'b10;

    // DST adjustment waiting to be applied at commit
    typedef enum logic [1:0] {
        DST_NONE  = 2'd0,
        DST_PLUS  = 2'd1,
        DST_MINUS = 2'd2
    } dst_pend_t;

    function automatic logic [c_HR_W-1:0] hr_inc(input logic [c_HR_W-1:0] h);
        return (h >= HR_MAX) ? '0 : h + 5'd1;
    endfunction

    function automatic logic [c_HR_W-1:0] hr_dec(input logic [c_HR_W-1:0] h);
        return (h == '0 || h > HR_MAX) ? HR_MAX : h - 5'd1;
    endfunction

    function automatic logic [c_MIN_W-1:0] min_inc(input logic [c_MIN_W-1:0] m);
        return (m >= MIN_MAX) ? '0 : m + 6'd1;
    endfunction

    function automatic logic [c_MIN_W-1:0] min_dec(input logic [c_MIN_W-1:0] m);
        return (m == '0 || m > MIN_MAX) ? MIN_MAX : m - 6'd1;
    endfunction

    // Apply a pending DST shift to an hour value
    function automatic logic [c_HR_W-1:0] hr_adjust(input logic [c_HR_W-1:0] h,
                                                    input dst_pend_t      p);
        case (p)
            DST_PLUS:  return hr_inc(h);
            DST_MINUS: return hr_dec(h);
            default:   return h;
        endcase
    endfunction

    // Fold new DST edges into the pending shift; opposite edges cancel
    function automatic dst_pend_t pend_next(input dst_pend_t p,
                                            input logic      up,
                                            input logic      dn);
        if (up && !dn)
            return (p == DST_MINUS) ? DST_NONE : DST_PLUS;
        else if (dn && !up)
            return (p == DST_PLUS) ? DST_NONE : DST_MINUS;
        else
            return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clock_set_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : clock_set_ctrl_if
//  Description : Button / DST / counter-load bundle between the debouncers,
//                the clock counter and the time-setting controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface clock_set_ctrl_if;
    import clock_pkg::*;

    logic                btn_mode;
    logic                btn_inc;
    logic                btn_dec;
    logic                dst_en;
    logic [c_TIME_W-1:0] cur_time;
    logic                run_en;
    logic                load;
    logic [c_TIME_W-1:0] load_time;
    logic [c_HR_W-1:0]   edit_hr;
    logic [c_MIN_W-1:0]  edit_min;
    logic [1:0]          field;
    logic                blink;

    // Environment side: drives buttons and live time, observes controls
    modport master (
        output btn_mode, btn_inc, btn_dec, dst_en, cur_time,
        input  run_en, load, load_time, edit_hr, edit_min, field, blink
    );

    // Controller side
    modport slave (
        input  btn_mode, btn_inc, btn_dec, dst_en, cur_time,
        output run_en, load, load_time, edit_hr, edit_min, field, blink
    );

endinterface
`default_nettype wire

// File: rtl/clock_set_ctrl_btn_repeat.sv
`default_nettype none
// ============================================================================
//  Module      : btn_repeat
//  Description : Rising-edge detector with hold-then-repeat auto-fire.
//                evt pulses one cycle on the press edge, HOLD_MS cycles
//                later, then every REPEAT_MS cycles while held.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_repeat #(
    parameter int HOLD_MS   = 500,
    parameter int REPEAT_MS = 100
) (
    input  wire  kh_clk,
    input  wire  reset,
    input  wire  btn,
    input  wire  restart,
    output logic evt
);

    localparam int c_CNT_MAX = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_HOLD   = c_CNT_W'(HOLD_MS);
    localparam logic [c_CNT_W-1:0] c_REPEAT = c_CNT_W'(REPEAT_MS);

    logic               r_btn_q;
    logic               r_repeat;
    logic [c_CNT_W-1:0] r_cnt;

    // Edge detect and hold/repeat timing; r_cnt counts cycles since last event
    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            r_btn_q  <= 1'b0;
            r_repeat <= 1'b0;
            r_cnt    <= '0;
            evt      <= 1'b0;
        end else begin
            r_btn_q <= btn;
            evt     <= 1'b0;
            if (btn && !r_btn_q) begin
                evt      <= 1'b1;
                r_cnt    <= c_ONE;
                r_repeat <= 1'b0;
            end else if (!btn) begin
                r_cnt    <= '0;
                r_repeat <= 1'b0;
            end else if (restart) begin
                r_cnt    <= c_ONE;
                r_repeat <= 1'b0;
            end else if ((!r_repeat && r_cnt == c_HOLD) ||
                         ( r_repeat && r_cnt == c_REPEAT)) begin
                evt      <= 1'b1;
                r_cnt    <= c_ONE;
                r_repeat <= 1'b1;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : clock_set_ctrl
//  Description : Hour-then-minute time editor and DST adjuster for the
//                12-hour clock counter. Holds the counter while editing and
//                commits the result with a one-cycle load strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int HOLD_MS    = 500,
    parameter int REPEAT_MS  = 100,
    parameter int TIMEOUT_MS = 10000,
    parameter int BLINK_MS   = 250
) (
    input  wire              kh_clk,
    input  wire              reset,
    clock_set_ctrl_if.slave  bus
);

    localparam int c_TMO_W   = $clog2(TIMEOUT_MS + 1);
    localparam int c_BLINK_W = $clog2(BLINK_MS + 1);

    localparam logic [c_TMO_W-1:0]   c_TMO_LAST   = c_TMO_W'(TIMEOUT_MS - 1);
    localparam logic [c_TMO_W-1:0]   c_TMO_ONE    = c_TMO_W'(1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_MS - 1);
    localparam logic [c_BLINK_W-1:0] c_BLINK_ONE  = c_BLINK_W'(1);

    logic w_inc_evt;
    logic w_dec_evt;
    logic w_both;
    logic w_inc;
    logic w_dec;

    logic r_mode_q;
    logic r_mode_evt;
    logic r_dst_q;
    logic r_dst_up;
    logic r_dst_dn;

    state_t                r_state;
    dst_pend_t             r_dst_pend;
    logic [c_TMO_W-1:0]    r_tmo_cnt;
    logic [c_BLINK_W-1:0]  r_blink_cnt;
    logic                  r_run_en;
    logic                  r_load;
    logic [c_TIME_W-1:0]   r_load_time;
    logic [c_HR_W-1:0]     r_edit_hr;
    logic [c_MIN_W-1:0]    r_edit_min;
    logic [1:0]            r_field;
    logic                  r_blink;

    clk_time_t             w_cur;
    dst_pend_t             w_pend_nxt;
    logic [c_HR_W-1:0]     w_commit_hr;

    // Coincident inc and dec cancel each other and restart both timers
    assign w_both = w_inc_evt & w_dec_evt;
    assign w_inc  = w_inc_evt & ~w_dec_evt;
    assign w_dec  = w_dec_evt & ~w_inc_evt;

    assign w_cur       = clk_time_t'(bus.cur_time);
    assign w_pend_nxt  = pend_next(r_dst_pend, r_dst_up, r_dst_dn);
    assign w_commit_hr = hr_adjust(r_edit_hr, w_pend_nxt);

    btn_repeat #(
        .HOLD_MS   (HOLD_MS),
        .REPEAT_MS (REPEAT_MS)
    ) u_inc (
        .kh_clk  (kh_clk),
        .reset   (reset),
        .btn     (bus.btn_inc),
        .restart (w_both),
        .evt     (w_inc_evt)
    );

    btn_repeat #(
        .HOLD_MS   (HOLD_MS),
        .REPEAT_MS (REPEAT_MS)
    ) u_dec (
        .kh_clk  (kh_clk),
        .reset   (reset),
        .btn     (bus.btn_dec),
        .restart (w_both),
        .evt     (w_dec_evt)
    );

    // Registered edge detection for the mode button and the DST level
    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            r_mode_q   <= 1'b0;
            r_mode_evt <= 1'b0;
            r_dst_q    <= 1'b0;
            r_dst_up   <= 1'b0;
            r_dst_dn   <= 1'b0;
        end else begin
            r_mode_q   <= bus.btn_mode;
            r_mode_evt <= bus.btn_mode & ~r_mode_q;
            r_dst_q    <= bus.dst_en;
            r_dst_up   <= bus.dst_en & ~r_dst_q;
            r_dst_dn   <= ~bus.dst_en & r_dst_q;
        end
    end

    // Edit state machine with registered outputs, timeout and blink timing
    always_ff @(posedge kh_clk or posedge reset) begin
        if (reset) begin
            r_state     <= RUN;
            r_dst_pend  <= DST_NONE;
            r_tmo_cnt   <= '0;
            r_blink_cnt <= '0;
            r_run_en    <= 1'b1;
            r_load      <= 1'b0;
            r_load_time <= '0;
            r_edit_hr   <= '0;
            r_edit_min  <= '0;
            r_field     <= c_FIELD_NONE;
            r_blink     <= 1'b0;
        end else begin
            r_load <= 1'b0;
            case (r_state)
                RUN: begin
                    r_run_en    <= 1'b1;
                    r_field     <= c_FIELD_NONE;
                    r_blink     <= 1'b0;
                    r_blink_cnt <= '0;
                    r_tmo_cnt   <= '0;
                    if (r_mode_evt) begin
                        // A DST edge coinciding with entry becomes pending
                        r_edit_hr  <= w_cur.hr;
                        r_edit_min <= w_cur.min;
                        r_dst_pend <= pend_next(DST_NONE, r_dst_up, r_dst_dn);
                        r_state    <= SET_HR;
                        r_field    <= c_FIELD_HR;
                        r_run_en   <= 1'b0;
                        r_blink    <= 1'b1;
                    end else if (r_dst_up) begin
                        r_load      <= 1'b1;
                        r_load_time <= {hr_inc(w_cur.hr), w_cur.min, w_cur.sec, w_cur.ms};
                    end else if (r_dst_dn) begin
                        r_load      <= 1'b1;
                        r_load_time <= {hr_dec(w_cur.hr), w_cur.min, w_cur.sec, w_cur.ms};
                    end
                end

                SET_HR, SET_MIN: begin
                    r_dst_pend <= w_pend_nxt;
                    if (r_mode_evt) begin
                        r_tmo_cnt   <= '0;
                        r_blink_cnt <= '0;
                        if (r_state == SET_HR) begin
                            r_state <= SET_MIN;
                            r_field <= c_FIELD_MIN;
                            r_blink <= 1'b1;
                        end else begin
                            r_state     <= COMMIT;
                            r_field     <= c_FIELD_NONE;
                            r_blink     <= 1'b0;
                            r_load      <= 1'b1;
                            r_edit_hr   <= w_commit_hr;
                            r_load_time <= {w_commit_hr, r_edit_min, 6'd0, 10'd0};
                            r_dst_pend  <= DST_NONE;
                        end
                    end else if (w_inc || w_dec) begin
                        r_tmo_cnt   <= '0;
                        r_blink     <= 1'b1;
                        r_blink_cnt <= '0;
                        if (r_state == SET_HR)
                            r_edit_hr  <= w_inc ? hr_inc(r_edit_hr) : hr_dec(r_edit_hr);
                        else
                            r_edit_min <= w_inc ? min_inc(r_edit_min) : min_dec(r_edit_min);
                    end else if (!w_both && r_tmo_cnt == c_TMO_LAST) begin
                        // Abandon the edit: no load, pending DST dropped
                        r_state     <= RUN;
                        r_field     <= c_FIELD_NONE;
                        r_run_en    <= 1'b1;
                        r_blink     <= 1'b0;
                        r_blink_cnt <= '0;
                        r_tmo_cnt   <= '0;
                        r_dst_pend  <= DST_NONE;
                    end else begin
                        r_tmo_cnt <= w_both ? '0 : r_tmo_cnt + c_TMO_ONE;
                        if (r_blink_cnt == c_BLINK_LAST) begin
                            r_blink_cnt <= '0;
                            r_blink     <= ~r_blink;
                        end else begin
                            r_blink_cnt <= r_blink_cnt + c_BLINK_ONE;
                        end
                    end
                end

                COMMIT: begin
                    r_state  <= RUN;
                    r_run_en <= 1'b1;
                end

                default: r_state <= RUN;
            endcase
        end
    end

    assign bus.run_en    = r_run_en;
    assign bus.load      = r_load;
    assign bus.load_time = r_load_time;
    assign bus.edit_hr   = r_edit_hr;
    assign bus.edit_min  = r_edit_min;
    assign bus.field     = r_field;
    assign bus.blink     = r_blink;

endmodule
`default_nettype wire

// File: tb/tb_clock_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_set_ctrl
//  Description : Directed self-checking bench for clock_set_ctrl; committed
//                and DST load values are queued as expectations and matched
//                when the load strobe appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_set_ctrl;

    logic kh_clk;
    logic reset;

    clock_set_ctrl_if bus ();

    clock_set_ctrl dut (
        .kh_clk (kh_clk),
        .reset  (reset),
        .bus    (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [26:0] exp_q[$];
    logic [26:0] exp_lt;

    initial kh_clk = 1'b0;
    always #5 kh_clk = ~kh_clk;

    function automatic logic [26:0] tm(input int hr, input int mn, input int sc, input int ms);
        return {5'(hr), 6'(mn), 6'(sc), 10'(ms)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge kh_clk);
        #1;
    endtask

    // Press for one sample edge, release, then wait until outputs reflect it
    task automatic press(input logic m, input logic i, input logic d);
        bus.btn_mode = m;
        bus.btn_inc  = i;
        bus.btn_dec  = d;
        step();
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
        step();
    endtask

    // Scoreboard: every load must match the oldest queued expectation
    always @(negedge kh_clk) begin
        if (!reset && bus.load === 1'b1) begin
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL load_unexpected: observed load_time %h expected no load", bus.load_time);
            end else begin
                exp_lt = exp_q.pop_front();
                assert (bus.load_time === exp_lt) else begin
                    n_fail++;
                    $error("FAIL load_time: observed %h expected %h", bus.load_time, exp_lt);
                end
            end
        end
    end

    initial begin
        int exp_hr[3];
        exp_hr = '{11, 0, 1};

        reset        = 1'b1;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
        bus.dst_en   = 1'b0;
        bus.cur_time = '0;
        repeat (3) step();

        chk("rst_run_en",    32'(bus.run_en),    1);
        chk("rst_load",      32'(bus.load),      0);
        chk("rst_load_time", 32'(bus.load_time), 0);
        chk("rst_edit_hr",   32'(bus.edit_hr),   0);
        chk("rst_edit_min",  32'(bus.edit_min),  0);
        chk("rst_field",     32'(bus.field),     0);
        chk("rst_blink",     32'(bus.blink),     0);
        reset = 1'b0;
        step();

        // Full edit sequence from 10:00
        bus.cur_time = tm(10, 0, 12, 345);
        press(1, 0, 0);
        chk("enter_field",  32'(bus.field),    1);
        chk("enter_run_en", 32'(bus.run_en),   0);
        chk("enter_hr",     32'(bus.edit_hr),  10);
        chk("enter_min",    32'(bus.edit_min), 0);
        chk("enter_blink",  32'(bus.blink),    1);
        for (int k = 0; k < 3; k++) begin
            press(0, 1, 0);
            chk("hr_inc", 32'(bus.edit_hr), 32'(exp_hr[k]));
        end
        press(1, 0, 0);
        chk("min_field",  32'(bus.field),  2);
        chk("min_run_en", 32'(bus.run_en), 0);
        press(0, 0, 1);
        chk("min_dec0", 32'(bus.edit_min), 59);
        press(0, 0, 1);
        chk("min_dec1", 32'(bus.edit_min), 58);
        exp_q.push_back(tm(1, 58, 0, 0));
        press(1, 0, 0);
        chk("commit_load",   32'(bus.load),   1);
        chk("commit_run_en", 32'(bus.run_en), 0);
        chk("commit_field",  32'(bus.field),  0);
        step();
        chk("post_load",   32'(bus.load),   0);
        chk("post_run_en", 32'(bus.run_en), 1);

        // Hold-to-repeat in the minute field
        bus.cur_time = tm(3, 0, 0, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        chk("hold_start", 32'(bus.edit_min), 0);
        bus.btn_inc = 1'b1;
        step();
        step();
        chk("hold_edge", 32'(bus.edit_min), 1);
        repeat (499) step();
        chk("hold_before_500", 32'(bus.edit_min), 1);
        step();
        chk("hold_at_500", 32'(bus.edit_min), 2);
        repeat (299) step();
        bus.btn_inc = 1'b0;
        step();
        chk("hold_final", 32'(bus.edit_min), 5);
        exp_q.push_back(tm(3, 5, 0, 0));
        press(1, 0, 0);
        chk("hold_commit", 32'(bus.load), 1);
        step();

        // Idle timeout in SET_HR, with blink phase check on the way
        bus.cur_time = tm(7, 20, 0, 0);
        press(1, 0, 0);
        chk("tmo_field_in", 32'(bus.field), 1);
        repeat (249) step();
        chk("blink_before", 32'(bus.blink), 1);
        step();
        chk("blink_toggle", 32'(bus.blink), 0);
        repeat (9749) step();
        chk("tmo_not_yet", 32'(bus.field), 1);
        step();
        chk("tmo_field",  32'(bus.field),  0);
        chk("tmo_run_en", 32'(bus.run_en), 1);
        chk("tmo_load",   32'(bus.load),   0);
        chk("tmo_blink",  32'(bus.blink),  0);

        // DST edges while running
        bus.cur_time = tm(11, 30, 45, 678);
        exp_q.push_back(tm(0, 30, 45, 678));
        bus.dst_en = 1'b1;
        step();
        step();
        chk("dst_up_load",   32'(bus.load),   1);
        chk("dst_up_run_en", 32'(bus.run_en), 1);
        step();
        chk("dst_up_done", 32'(bus.load), 0);
        bus.cur_time = tm(0, 30, 45, 678);
        exp_q.push_back(tm(11, 30, 45, 678));
        bus.dst_en = 1'b0;
        step();
        step();
        chk("dst_dn_load", 32'(bus.load), 1);
        step();

        // DST edge during edit is applied at commit
        bus.cur_time = tm(5, 10, 0, 0);
        press(1, 0, 0);
        bus.dst_en = 1'b1;
        step();
        step();
        chk("dst_edit_noload", 32'(bus.load),    0);
        chk("dst_edit_hr",     32'(bus.edit_hr), 5);
        press(1, 0, 0);
        exp_q.push_back(tm(6, 10, 0, 0));
        press(1, 0, 0);
        chk("dst_commit_load", 32'(bus.load),    1);
        chk("dst_commit_hr",   32'(bus.edit_hr), 6);
        step();

        // Opposite DST edges during edit cancel
        bus.cur_time = tm(8, 40, 0, 0);
        press(1, 0, 0);
        bus.dst_en = 1'b0;
        step();
        step();
        bus.dst_en = 1'b1;
        step();
        step();
        press(1, 0, 0);
        exp_q.push_back(tm(8, 40, 0, 0));
        press(1, 0, 0);
        chk("cancel_hr", 32'(bus.edit_hr), 8);
        step();

        // Mode beats inc, inc+dec ignored, reset aborts the edit
        bus.cur_time = tm(4, 15, 0, 0);
        press(1, 0, 0);
        press(1, 1, 0);
        chk("modeinc_field", 32'(bus.field),   2);
        chk("modeinc_hr",    32'(bus.edit_hr), 4);
        press(0, 1, 0);
        chk("min_inc", 32'(bus.edit_min), 16);
        press(0, 1, 1);
        chk("incdec_ignored", 32'(bus.edit_min), 16);
        bus.dst_en = 1'b0;
        step();
        step();
        reset = 1'b1;
        #1;
        chk("abort_field",  32'(bus.field),    0);
        chk("abort_run_en", 32'(bus.run_en),   1);
        chk("abort_load",   32'(bus.load),     0);
        chk("abort_min",    32'(bus.edit_min), 0);
        step();
        reset = 1'b0;
        repeat (5) step();
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
